// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream input and instruction-memory write bus
// of the instruction memory loader.
//   master : the loader (consumes bytes, drives memory writes)
//   slave  : the environment (supplies bytes, observes memory writes)
interface instr_mem_loader_if #(
    parameter int BYTE_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     byte_valid;
    logic [BYTE_WIDTH-1:0]    byte_data;
    logic                     byte_last;
    logic                     byte_ready;
    logic                     WE;
    logic [ADDRESS_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0]    WD;

    modport master (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, WE, A, WD
    );

    modport slave (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, WE, A, WD
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a program image as a little-endian byte stream,
// packs 4 bytes per word and writes the words into instruction memory from
// BASE_ADDR upward, holding the CPU in reset until the image is in place.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running byte checksum
// output (modulo 2^BYTE_WIDTH sum of accepted image bytes).
module instr_mem_loader #(
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     BYTE_WIDTH    = 8,
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = 32'hBFC00000,
    parameter int                     MEM_BYTES     = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_mem_loader_if.master     bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   cpu_hold
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [BYTE_WIDTH-1:0]  checksum
`endif
);

    localparam int CW = $clog2(MEM_BYTES + 1);
    localparam logic [CW-1:0]            FULL_COUNT = CW'(MEM_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP  = ADDRESS_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CW-1:0]            r_count;
    logic [DATA_WIDTH-1:0]    r_pack;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_last_seen;
    logic                     r_err;
    logic                     r_byte_ready;
    logic                     r_we;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_cpu_hold;

    logic                     w_xfer;
    logic                     w_ovf;
    logic                     w_start_ok;
    logic                     w_word_end;

    // Place a byte into its little-endian lane of the pack register.
    function automatic logic [DATA_WIDTH-1:0] insert_byte(
        input logic [DATA_WIDTH-1:0] pack,
        input logic [1:0]            lane,
        input logic [BYTE_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] res;
        res = pack;
        case (lane)
            2'd0:    res[0*BYTE_WIDTH +: BYTE_WIDTH] = b;
            2'd1:    res[1*BYTE_WIDTH +: BYTE_WIDTH] = b;
            2'd2:    res[2*BYTE_WIDTH +: BYTE_WIDTH] = b;
            2'd3:    res[3*BYTE_WIDTH +: BYTE_WIDTH] = b;
            default: res = pack;
        endcase
        return res;
    endfunction

    assign w_xfer     = (r_state == S_RECV) && r_byte_ready && bus.byte_valid;
    // Memory is already full: any further byte cannot belong to a written word.
    assign w_ovf      = w_xfer && (r_count == FULL_COUNT);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_word_end = (r_count[1:0] == 2'd3) || bus.byte_last;

    // Next-state decode of the load sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RECV;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RECV: begin
                if (w_ovf) begin
                    w_state_nxt = S_DONE;
                end else if (w_xfer && w_word_end) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            S_WRITE: begin
                if (r_last_seen) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and status/handshake outputs registered from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_hold   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ready <= (w_state_nxt == S_RECV);
            r_we         <= (w_state_nxt == S_WRITE);
            r_busy       <= (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE);
            r_done       <= (w_state_nxt == S_DONE);
            r_cpu_hold   <= (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE);
        end
    end

    // Byte packing, byte count, write address and overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_pack      <= '0;
            r_addr      <= BASE_ADDR;
            r_last_seen <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_start_ok) begin
            r_count     <= '0;
            r_pack      <= '0;
            r_addr      <= BASE_ADDR;
            r_last_seen <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_ovf) begin
            // Overflow byte is consumed but never stored.
            r_err       <= 1'b1;
        end else if (w_xfer) begin
            r_pack      <= insert_byte(r_pack, r_count[1:0], bus.byte_data);
            r_count     <= r_count + CW'(1);
            r_last_seen <= bus.byte_last;
        end else if (r_state == S_WRITE) begin
            // Word has been presented this cycle; a short final word was
            // already zero-padded by the cleared pack register.
            r_pack      <= '0;
            r_addr      <= r_addr + WORD_STEP;
        end else begin
            r_pack      <= r_pack;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] r_checksum;

    // Running sum of stored image bytes; overflow bytes are excluded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_xfer && !w_ovf) begin
            r_checksum <= r_checksum + bus.byte_data;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`endif

    assign bus.byte_ready = r_byte_ready;
    assign bus.WE         = r_we;
    assign bus.A          = r_addr;
    assign bus.WD         = r_pack;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign cpu_hold       = r_cpu_hold;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed tests of the instruction memory loader,
// built with MEM_BYTES=8 so the overflow boundary is reachable quickly.
module tb_instr_mem_loader;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic err;
    logic cpu_hold;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks;
    int errors;
    int bad_ready;
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];

    instr_mem_loader_if #(.BYTE_WIDTH(8), .DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    instr_mem_loader #(
        .DATA_WIDTH(32),
        .BYTE_WIDTH(8),
        .ADDRESS_WIDTH(32),
        .BASE_ADDR(32'hBFC00000),
        .MEM_BYTES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .err(err),
        .cpu_hold(cpu_hold)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every memory write presented at a clock edge.
    always @(posedge clk) begin
        if (bus.WE === 1'b1) begin
            wr_a.push_back(bus.A);
            wr_d.push_back(bus.WD);
            if (bus.byte_ready !== 1'b0) bad_ready++;
        end
    end

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
        bad_ready = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input string tag);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        bus.byte_last  = last;
        while (!ok && n < 20) begin
            @(posedge clk);
            n++;
            if (bus.byte_ready === 1'b1) ok = 1'b1;
        end
        #1;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s byte_accept: byte %h not accepted, got timeout, expected ready", tag, b);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_wait: done=%b after %0d cycles, expected 1", tag, done, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_cycles(2);
        checks += 8;
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset byte_ready: got %b expected 0", bus.byte_ready); end
        if (bus.WE !== 1'b0)         begin errors++; $display("FAIL reset WE: got %b expected 0", bus.WE); end
        if (bus.A !== 32'hBFC00000)  begin errors++; $display("FAIL reset A: got %h expected bfc00000", bus.A); end
        if (bus.WD !== 32'h0)        begin errors++; $display("FAIL reset WD: got %h expected 00000000", bus.WD); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0)           begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        if (err !== 1'b0)            begin errors++; $display("FAIL reset err: got %b expected 0", err); end
        if (cpu_hold !== 1'b0)       begin errors++; $display("FAIL reset cpu_hold: got %b expected 0", cpu_hold); end
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_two_words();
        logic [7:0]  img[8];
        logic [31:0] exp_a[2];
        logic [31:0] exp_d[2];
        img   = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_a = '{32'hBFC00000, 32'hBFC00004};
        exp_d = '{32'h00000013, 32'h00100093};
        clear_log();
        pulse_start();
        checks += 3;
        if (busy !== 1'b1)           begin errors++; $display("FAIL two_words busy_start: got %b expected 1", busy); end
        if (cpu_hold !== 1'b1)       begin errors++; $display("FAIL two_words hold_start: got %b expected 1", cpu_hold); end
        if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL two_words ready_start: got %b expected 1", bus.byte_ready); end
        for (int i = 0; i < 8; i++) send_byte(img[i], (i == 7), "two_words");
        wait_done("two_words");
        idle_cycles(3);
        checks++;
        if (wr_a.size() != 2) begin errors++; $display("FAIL two_words write_count: got %0d expected 2", wr_a.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= wr_a.size() || wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL two_words write%0d: got A=%h WD=%h expected A=%h WD=%h", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
            end
        end
        checks += 3;
        if (err !== 1'b0)      begin errors++; $display("FAIL two_words err: got %b expected 0", err); end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL two_words hold_end: got %b expected 0", cpu_hold); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL two_words busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_partial();
        clear_log();
        pulse_start();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL partial done_cleared: got %b expected 0", done); end
        send_byte(8'hAA, 1'b0, "partial");
        // start while receiving must not restart the load
        pulse_start();
        send_byte(8'hBB, 1'b0, "partial");
        send_byte(8'hCC, 1'b1, "partial");
        wait_done("partial");
        idle_cycles(2);
        checks += 3;
        if (wr_a.size() != 1) begin errors++; $display("FAIL partial write_count: got %0d expected 1", wr_a.size()); end
        if (wr_a.size() < 1 || wr_a[0] !== 32'hBFC00000 || wr_d[0] !== 32'h00CCBBAA) begin
            errors++;
            $display("FAIL partial write0: got A=%h WD=%h expected A=bfc00000 WD=00ccbbaa", wr_a[0], wr_d[0]);
        end
        if (err !== 1'b0) begin errors++; $display("FAIL partial err: got %b expected 0", err); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1), (i == 7), "backpressure");
            idle_cycles(1);
        end
        wait_done("backpressure");
        idle_cycles(2);
        checks += 4;
        if (wr_a.size() != 2) begin errors++; $display("FAIL backpressure write_count: got %0d expected 2", wr_a.size()); end
        if (wr_a.size() < 1 || wr_a[0] !== 32'hBFC00000 || wr_d[0] !== 32'h04030201) begin
            errors++;
            $display("FAIL backpressure write0: got A=%h WD=%h expected A=bfc00000 WD=04030201", wr_a[0], wr_d[0]);
        end
        if (wr_a.size() < 2 || wr_a[1] !== 32'hBFC00004 || wr_d[1] !== 32'h08070605) begin
            errors++;
            $display("FAIL backpressure write1: got A=%h WD=%h expected A=bfc00004 WD=08070605", wr_a[1], wr_d[1]);
        end
        if (bad_ready != 0) begin errors++; $display("FAIL backpressure ready_in_write: got %0d expected 0", bad_ready); end
    endtask

    task automatic test_overflow();
        clear_log();
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0, "overflow");
        wait_done("overflow");
        idle_cycles(3);
        checks += 5;
        if (err !== 1'b1)     begin errors++; $display("FAIL overflow err: got %b expected 1", err); end
        if (wr_a.size() != 2) begin errors++; $display("FAIL overflow write_count: got %0d expected 2", wr_a.size()); end
        if (wr_a.size() < 1 || wr_a[0] !== 32'hBFC00000 || wr_d[0] !== 32'h13121110) begin
            errors++;
            $display("FAIL overflow write0: got A=%h WD=%h expected A=bfc00000 WD=13121110", wr_a[0], wr_d[0]);
        end
        if (wr_a.size() < 2 || wr_a[1] !== 32'hBFC00004 || wr_d[1] !== 32'h17161514) begin
            errors++;
            $display("FAIL overflow write1: got A=%h WD=%h expected A=bfc00004 WD=17161514", wr_a[1], wr_d[1]);
        end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL overflow hold: got %b expected 0", cpu_hold); end
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start();
        send_byte(8'h55, 1'b0, "reset_mid");
        send_byte(8'h66, 1'b0, "reset_mid");
        rst_n = 1'b0;
        idle_cycles(1);
        checks += 6;
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        if (cpu_hold !== 1'b0)       begin errors++; $display("FAIL reset_mid hold: got %b expected 0", cpu_hold); end
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_mid ready: got %b expected 0", bus.byte_ready); end
        if (bus.WD !== 32'h0)        begin errors++; $display("FAIL reset_mid WD: got %h expected 00000000", bus.WD); end
        if (bus.A !== 32'hBFC00000)  begin errors++; $display("FAIL reset_mid A: got %h expected bfc00000", bus.A); end
        if (err !== 1'b0)            begin errors++; $display("FAIL reset_mid err: got %b expected 0", err); end
        rst_n = 1'b1;
        idle_cycles(4);
        checks++;
        if (wr_a.size() != 0) begin errors++; $display("FAIL reset_mid no_write: got %0d expected 0", wr_a.size()); end
        pulse_start();
        send_byte(8'hDE, 1'b0, "reset_mid");
        send_byte(8'hAD, 1'b0, "reset_mid");
        send_byte(8'hBE, 1'b0, "reset_mid");
        send_byte(8'hEF, 1'b1, "reset_mid");
        wait_done("reset_mid");
        checks++;
        if (wr_a.size() != 1 || wr_a[0] !== 32'hBFC00000 || wr_d[0] !== 32'hEFBEADDE) begin
            errors++;
            $display("FAIL reset_mid fresh_write: got n=%0d A=%h WD=%h expected n=1 A=bfc00000 WD=efbeadde", wr_a.size(), wr_a[0], wr_d[0]);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_byte(8'hFF, 1'b0, "checksum");
        send_byte(8'h02, 1'b0, "checksum");
        send_byte(8'h10, 1'b1, "checksum");
        wait_done("checksum");
        idle_cycles(2);
        checks++;
        if (checksum !== 8'h11) begin errors++; $display("FAIL checksum done_value: got %h expected 11", checksum); end
        pulse_start();
        checks++;
        if (checksum !== 8'h00) begin errors++; $display("FAIL checksum cleared: got %h expected 00", checksum); end
    endtask
`endif

    initial begin
        checks         = 0;
        errors         = 0;
        bad_ready      = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_last  = 1'b0;
        test_reset();
        test_two_words();
        test_partial();
        test_back_to_back();
        test_overflow();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Write-side counterpart of the byte-addressed, little-endian instruction ROM at base 0xBFC00000. Accepts a program image as a byte stream over a valid/ready handshake and packs every 4 bytes into a 32-bit word. Issues one word write per packed word into the writable instruction memory, starting at BASE_ADDR. Holds the CPU core in reset (cpu_hold) from start until the image is fully written.

Parameters:
DATA_WIDTH, 32, write-data width; must equal 4*BYTE_WIDTH
BYTE_WIDTH, 8, stream byte width
ADDRESS_WIDTH, 32, write-address width
BASE_ADDR, 32'hBFC00000, byte address of the first word written
MEM_BYTES, 4096, capacity in bytes; a multiple of 4

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begin a load (ignored unless IDLE or DONE)
byte_valid  input  1  stream byte present
byte_data  input  BYTE_WIDTH  stream byte
byte_last  input  1  qualifies final byte of image (with byte_valid)
byte_ready  output  1  loader accepts byte this cycle
WE  output  1  memory word write enable
A  output  ADDRESS_WIDTH  memory byte address, word aligned
WD  output  DATA_WIDTH  memory write data
busy  output  1  load in progress
done  output  1  load finished; held until next start or reset
err  output  1  overflow occurred during last load; held like done
cpu_hold  output  1  high from start until done

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; byte_ready=0, WE=0, A=BASE_ADDR, WD=0, busy=0, done=0, err=0, cpu_hold=0; byte counter and pack register cleared. Reset mid-load abandons the load; no further WE.
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE + start: next cycle RECV. Clear done, err, byte count and pack register. Set busy=1, cpu_hold=1.
- RECV: byte_ready=1. A byte transfers when byte_valid&&byte_ready at the edge.
  - Byte k of a word (k = count[1:0]) goes to pack[8k+7:8k], so the first byte lands in bits [7:0].
  - On the 4th byte, or on byte_last: go to WRITE.
- WRITE: exactly 1 cycle. WE=1, WD=pack, A=BASE_ADDR + 4*word_index; byte_ready=0.
  - Bytes missing from a partial final word are written as 0x00.
  - Next state: DONE if last seen, otherwise RECV. word_index increments and pack clears.
- DONE: done=1, busy=0, cpu_hold=0, byte_ready=0.
- Throughput: 4 bytes per 5 cycles at best (4 RECV + 1 WRITE).
- A and WD are registered; WE is asserted only in WRITE. A increments by 4 per write and never wraps.
- Overflow: if a byte is offered after MEM_BYTES bytes have been accepted and the byte is not a continuation of the last word, then:
  - The byte is accepted and discarded.
  - err=1 and the state goes to DONE.
  - No write occurs beyond BASE_ADDR+MEM_BYTES-4.
- byte_last on the exact MEM_BYTES-th byte: normal completion, err=0.
- start while in RECV/WRITE: ignored.
- byte_valid in IDLE/DONE: ignored (byte_ready=0).
- Empty image (start, then never valid): loader stays in RECV with cpu_hold=1.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: adds output port checksum [BYTE_WIDTH-1:0].
  - Holds the modulo-256 sum of all accepted bytes of the current load; pad bytes and discarded overflow bytes are excluded.
  - Cleared on reset and on start; updated the cycle after each transfer; stable in DONE.
- Not defined: no checksum port or logic; all other behaviour is identical.

Test Plan:
- Reset then start; stream 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 (last on 8th) -> two writes: A=0xBFC00000 WD=0x00000013, then A=0xBFC00004 WD=0x00100093; done=1, err=0, cpu_hold 1->0.
- Partial word: stream 0xAA,0xBB,0xCC with last on 0xCC -> one write A=0xBFC00000 WD=0x00CCBBAA; done=1.
- Backpressure: byte_valid toggling 1,0,1,0 and byte_ready=0 during WRITE -> no byte lost or duplicated; WE pulses exactly once per 4 bytes.
- Overflow with MEM_BYTES=8: stream 9 bytes, no last -> 2 writes (0xBFC00000, 0xBFC00004); 9th byte accepted, err=1, done=1; no WE at 0xBFC00008.
- Reset mid-load: rst_n low after 2 bytes -> all outputs at reset values next cycle; no WE. A fresh start+4 bytes writes at 0xBFC00000.
- With LOADER_CHECKSUM_EN: bytes 0xFF,0x02,0x10 with last -> checksum=0x11 in DONE; new start -> checksum=0x00.
